// File: rtl/sid_bus_master_if.sv
// sid_bus_master_if: command handshake, SID bus pins and read-return signals
// shared between the bus master and its environment.
interface sid_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd;
    logic        sid_cs;
    logic        sid_rw;
    logic [4:0]  sid_a;
    logic [7:0]  sid_di;
    logic [7:0]  sid_do;
    logic        rd_valid;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;

    modport master (
        input  cmd_valid, cmd, sid_do,
        output cmd_ready, sid_cs, sid_rw, sid_a, sid_di,
        output rd_valid, rd_addr, rd_data
    );

    modport slave (
        output cmd_valid, cmd, sid_do,
        input  cmd_ready, sid_cs, sid_rw, sid_a, sid_di,
        input  rd_valid, rd_addr, rd_data
    );
endinterface

// File: rtl/sid_bus_master.sv
// sid_bus_master: buffers 16-bit SID register commands in a FIFO and replays
// them as one bus window per phi2 period (write, read, wait, nop).
// Optional feature: define SID_READBACK_EN to make op 01 perform a read cycle
// and return the data on rd_valid/rd_addr/rd_data. Without it op 01 is a nop
// and the read-return outputs are tied low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no window active; bus outputs 0; pops at next phi2 if non-empty
// ST_BUS  | write/read window driven for one phi2 period
// ST_WAIT | bus idle for wait_cnt remaining phi2 periods
module sid_bus_master #(
    parameter int FIFO_AW = 3
) (
    input  logic             dot_clk,
    input  logic             reset,
    input  logic             phi2_en,
    sid_bus_master_if.master bus,
    output logic [FIFO_AW:0] level,
    output logic             busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       cs_q, cs_nx;
    logic       rw_q, rw_nx;
    logic [4:0] a_q, a_nx;
    logic [7:0] di_q, di_nx;

    // Bit 13 of the command is reserved and not stored.
    logic [14:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [14:0]        head;
    logic [1:0]         head_op;
    logic [4:0]         head_addr;
    logic [7:0]         head_data;

    logic push;
    logic pop;
    logic boundary;

    assign bus.cmd_ready = (level != FULL_LEVEL);
    assign push          = bus.cmd_valid && bus.cmd_ready;

    assign head      = fifo_mem[rd_ptr];
    assign head_op   = head[14:13];
    assign head_addr = head[12:8];
    assign head_data = head[7:0];

    // A window or wait ends and the next command starts on the same phi2 edge.
    assign boundary = phi2_en && ((state == ST_IDLE) || (state == ST_BUS) ||
                                  ((state == ST_WAIT) && (wait_cnt == 8'd1)));
    // Level before this edge's push: a same-edge push is not poppable yet.
    assign pop  = boundary && (level != '0);
    assign busy = (level != '0) || (state != ST_IDLE);

    assign bus.sid_cs = cs_q;
    assign bus.sid_rw = rw_q;
    assign bus.sid_a  = a_q;
    assign bus.sid_di = di_q;

    // Command storage array; contents need no reset since level gates reads.
    always_ff @(posedge dot_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd[15:14], bus.cmd[12:0]};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Sequencer state and registered bus outputs.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            cs_q     <= 1'b0;
            rw_q     <= 1'b0;
            a_q      <= '0;
            di_q     <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            cs_q     <= cs_nx;
            rw_q     <= rw_nx;
            a_q      <= a_nx;
            di_q     <= di_nx;
        end
    end

    // Next state: count down waits, and at a boundary launch the head command.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        cs_nx       = cs_q;
        rw_nx       = rw_q;
        a_nx        = a_q;
        di_nx       = di_q;

        if (phi2_en && (state == ST_WAIT) && (wait_cnt != 8'd1)) begin
            wait_cnt_nx = wait_cnt - 8'd1;
        end

        if (boundary) begin
            state_nx    = ST_IDLE;
            wait_cnt_nx = '0;
            cs_nx       = 1'b0;
            rw_nx       = 1'b0;
            a_nx        = '0;
            di_nx       = '0;
            if (pop) begin
                case (head_op)
                    OP_WRITE: begin
                        state_nx = ST_BUS;
                        cs_nx    = 1'b1;
                        rw_nx    = 1'b1;
                        a_nx     = head_addr;
                        di_nx    = head_data;
                    end
                    OP_READ: begin
`ifdef SID_READBACK_EN
                        state_nx = ST_BUS;
                        cs_nx    = 1'b1;
                        rw_nx    = 1'b0;
                        a_nx     = head_addr;
                        di_nx    = head_data;
`endif
                    end
                    OP_WAIT: begin
                        // A zero count is consumed like a nop.
                        if (head_data != 8'd0) begin
                            state_nx    = ST_WAIT;
                            wait_cnt_nx = head_data;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef SID_READBACK_EN
    logic       rd_fire;
    logic       rd_valid_q;
    logic [4:0] rd_addr_q;
    logic [7:0] rd_data_q;

    // A read window closes on the boundary edge ending its BUS period.
    assign rd_fire = boundary && (state == ST_BUS) && !rw_q;

    // Capture the SID's data and address as the read window closes.
    always_ff @(posedge dot_clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_addr_q <= a_q;
                rd_data_q <= bus.sid_do;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_data  = rd_data_q;
`else
    assign bus.rd_valid = 1'b0;
    assign bus.rd_addr  = '0;
    assign bus.rd_data  = '0;
`endif
endmodule

// File: tb/tb_sid_bus_master.sv
// tb_sid_bus_master: batches of commands are pushed with phi2 held low, then
// phi2 runs and every phi2 period is compared against a per-period timeline
// expanded from the command list.
module tb_sid_bus_master;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 8;

    logic             dot_clk = 1'b0;
    logic             reset;
    logic             phi2_en;
    logic [FIFO_AW:0] level;
    logic             busy;
    logic [7:0]       do_xor;

    sid_bus_master_if bus ();

    sid_bus_master #(.FIFO_AW(FIFO_AW)) dut (
        .dot_clk (dot_clk),
        .reset   (reset),
        .phi2_en (phi2_en),
        .bus     (bus.master),
        .level   (level),
        .busy    (busy)
    );

    always #5 dot_clk = ~dot_clk;

    // SID stand-in: read data is a simple function of the presented address.
    assign bus.sid_do = do_xor ^ {3'b000, bus.sid_a};

    typedef struct {
        logic       cs;
        logic       rw;
        logic [4:0] a;
        logic [7:0] di;
        logic [3:0] lvl;
        logic       bsy;
        logic       rd;
    } period_t;

    logic [15:0] cmd_q[$];
    period_t     exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge dot_clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [1:0] op, input logic [4:0] a,
                                       input logic [7:0] d);
        return {op, 1'b0, a, d};
    endfunction

    // Expand accepted commands into one entry per phi2 period.
    function automatic void build_expect();
        int      n;
        int      popped;
        logic [1:0] op;
        logic [4:0] addr;
        logic [7:0] data;
        period_t p;
        n = cmd_q.size();
        popped = 0;
        exp_q.delete();
        foreach (cmd_q[i]) begin
            op   = cmd_q[i][15:14];
            addr = cmd_q[i][12:8];
            data = cmd_q[i][7:0];
            popped++;
            p = '{cs: 1'b0, rw: 1'b0, a: 5'd0, di: 8'd0, lvl: 4'(n - popped),
                  bsy: (n - popped) != 0, rd: 1'b0};
            case (op)
                2'b00: begin
                    p.cs = 1'b1; p.rw = 1'b1; p.a = addr; p.di = data; p.bsy = 1'b1;
                    exp_q.push_back(p);
                end
                2'b01: begin
`ifdef SID_READBACK_EN
                    p.cs = 1'b1; p.rw = 1'b0; p.a = addr; p.di = data; p.bsy = 1'b1;
                    p.rd = 1'b1;
`endif
                    exp_q.push_back(p);
                end
                2'b10: begin
                    if (data == 8'd0) begin
                        exp_q.push_back(p);
                    end else begin
                        p.bsy = 1'b1;
                        repeat (data) exp_q.push_back(p);
                    end
                end
                default: exp_q.push_back(p);
            endcase
        end
        p = '{cs: 1'b0, rw: 1'b0, a: 5'd0, di: 8'd0, lvl: 4'd0, bsy: 1'b0, rd: 1'b0};
        exp_q.push_back(p);
        exp_q.push_back(p);
    endfunction

    task automatic push_cmd(input logic [15:0] c);
        logic exp_ready;
        exp_ready = (cmd_q.size() < DEPTH);
        bus.cmd_valid = 1'b1;
        bus.cmd = c;
        n_checks++;
        if (bus.cmd_ready !== exp_ready)
            $display("FAIL cmd_ready: got %b expected %b", bus.cmd_ready, exp_ready);
        else n_pass++;
        tick();
        bus.cmd_valid = 1'b0;
        if (exp_ready) cmd_q.push_back(c);
        n_checks++;
        if (level !== 4'(cmd_q.size()))
            $display("FAIL push_level: got %0d expected %0d", level, cmd_q.size());
        else n_pass++;
    endtask

    task automatic run_expect(input int per);
        period_t e;
        period_t pr;
        logic    hold_ok;
        logic [7:0] exp_rd;
        build_expect();
        for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            hold_ok = 1'b1;
            phi2_en = 1'b1;
            tick();
            phi2_en = 1'b0;
            n_checks++;
            if ({bus.sid_cs, bus.sid_rw, bus.sid_a, bus.sid_di} !== {e.cs, e.rw, e.a, e.di})
                $display("FAIL window[%0d]: got cs=%b rw=%b a=%h di=%h expected cs=%b rw=%b a=%h di=%h",
                         k, bus.sid_cs, bus.sid_rw, bus.sid_a, bus.sid_di, e.cs, e.rw, e.a, e.di);
            else n_pass++;
            n_checks++;
            if ({level, busy} !== {e.lvl, e.bsy})
                $display("FAIL level_busy[%0d]: got level=%0d busy=%b expected level=%0d busy=%b",
                         k, level, busy, e.lvl, e.bsy);
            else n_pass++;
            n_checks++;
            if (k > 0 && exp_q[k-1].rd) begin
                pr = exp_q[k-1];
                exp_rd = do_xor ^ {3'b000, pr.a};
                if ({bus.rd_valid, bus.rd_addr, bus.rd_data} !== {1'b1, pr.a, exp_rd})
                    $display("FAIL read_return[%0d]: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                             k, bus.rd_valid, bus.rd_addr, bus.rd_data, pr.a, exp_rd);
                else n_pass++;
            end else begin
                if (bus.rd_valid !== 1'b0)
                    $display("FAIL rd_valid_idle[%0d]: got %b expected 0", k, bus.rd_valid);
                else n_pass++;
            end
            for (int j = 1; j < per; j++) begin
                tick();
                if ({bus.sid_cs, bus.sid_rw, bus.sid_a, bus.sid_di} !== {e.cs, e.rw, e.a, e.di} ||
                    bus.rd_valid !== 1'b0)
                    hold_ok = 1'b0;
            end
            n_checks++;
            if (hold_ok !== 1'b1)
                $display("FAIL hold[%0d]: got unstable outputs expected steady for %0d cycles", k, per);
            else n_pass++;
        end
        cmd_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        phi2_en = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd = '0;
        do_xor = '0;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.sid_cs, bus.sid_rw, bus.sid_a, bus.sid_di, bus.rd_valid, bus.rd_addr,
             bus.rd_data, level, busy, bus.cmd_ready} !== {34'd0, 1'b1})
            $display("FAIL reset_values: got cs=%b rw=%b a=%h di=%h rv=%b ra=%h rd=%h lvl=%0d busy=%b rdy=%b expected all 0 with rdy=1",
                     bus.sid_cs, bus.sid_rw, bus.sid_a, bus.sid_di, bus.rd_valid, bus.rd_addr,
                     bus.rd_data, level, busy, bus.cmd_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_write();
        push_cmd(mk(2'b00, 5'h18, 8'h0F));
        run_expect(4);
    endtask

    task automatic test_back_to_back();
        push_cmd(mk(2'b00, 5'h00, 8'h11));
        push_cmd(mk(2'b00, 5'h01, 8'h22));
        push_cmd(mk(2'b00, 5'h04, 8'h41));
        run_expect(3);
    endtask

    task automatic test_wait();
        push_cmd(mk(2'b10, 5'h00, 8'd5));
        push_cmd(mk(2'b00, 5'h05, 8'h09));
        push_cmd(mk(2'b10, 5'h00, 8'd0));
        push_cmd(mk(2'b00, 5'h06, 8'h01));
        push_cmd(mk(2'b11, 5'h02, 8'h77));
        push_cmd(mk(2'b10, 5'h00, 8'd1));
        push_cmd(mk(2'b00, 5'h1F, 8'hEE));
        run_expect(2);
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH + 1; i++)
            push_cmd(mk(2'b00, 5'(i), 8'(8'h30 + i)));
        n_checks++;
        if ({bus.cmd_ready, level} !== {1'b0, 4'd8})
            $display("FAIL full: got ready=%b level=%0d expected ready=0 level=8", bus.cmd_ready, level);
        else n_pass++;
        run_expect(2);
    endtask

    task automatic test_read();
        do_xor = 8'hA5 ^ 8'h1C;
        push_cmd(mk(2'b01, 5'h1C, 8'h00));
        push_cmd(mk(2'b00, 5'h02, 8'h5A));
        push_cmd(mk(2'b01, 5'h19, 8'h00));
        run_expect(4);
    endtask

    task automatic test_same_edge();
        logic [15:0] c;
        c = mk(2'b00, 5'h02, 8'h33);
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd = c;
        phi2_en = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        phi2_en = 1'b0;
        n_checks++;
        if ({bus.sid_cs, level} !== {1'b0, 4'd1})
            $display("FAIL same_edge: got cs=%b level=%0d expected cs=0 level=1", bus.sid_cs, level);
        else n_pass++;
        cmd_q.push_back(c);
        tick();
        run_expect(3);
    endtask

    task automatic test_random();
        int n;
        logic [1:0] op;
        logic [7:0] d;
        for (int b = 0; b < 20; b++) begin
            do_xor = 8'($urandom);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                op = 2'($urandom_range(0, 3));
                d  = (op == 2'b10) ? 8'($urandom_range(0, 4)) : 8'($urandom);
                push_cmd({op, 1'($urandom), 5'($urandom), d});
            end
            run_expect($urandom_range(2, 5));
        end
    endtask

    task automatic test_reset_mid();
        logic quiet;
        push_cmd(mk(2'b00, 5'h07, 8'h55));
        push_cmd(mk(2'b01, 5'h08, 8'h66));
        push_cmd(mk(2'b00, 5'h09, 8'h77));
        phi2_en = 1'b1;
        tick();
        phi2_en = 1'b0;
        tick();
        n_checks++;
        if ({bus.sid_cs, bus.sid_a} !== {1'b1, 5'h07})
            $display("FAIL mid_window: got cs=%b a=%h expected cs=1 a=07", bus.sid_cs, bus.sid_a);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.sid_cs, bus.sid_rw, bus.sid_a, bus.sid_di, level, busy, bus.rd_valid} !== 21'd0)
            $display("FAIL reset_abort: got cs=%b a=%h level=%0d busy=%b rv=%b expected all 0",
                     bus.sid_cs, bus.sid_a, level, busy, bus.rd_valid);
        else n_pass++;
        cmd_q.delete();
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            phi2_en = 1'b1;
            tick();
            phi2_en = 1'b0;
            if (bus.sid_cs !== 1'b0 || level !== 4'd0 || bus.rd_valid !== 1'b0) quiet = 1'b0;
            tick();
            tick();
        end
        n_checks++;
        if (quiet !== 1'b1)
            $display("FAIL after_reset: got activity expected no windows");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait();
        test_full();
        test_read();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
